// File: rtl/rv_alu_decoder_pipe.sv
// rtl/rv_alu_decoder_pipe.sv - registered RISC-V OP/OP-32 ALU decoder with valid/ready handshake
// Define DECODER_IMM_EN to also decode OP-IMM (and OP-IMM-32 when XLEN=64).
module rv_alu_decoder_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [3:0]       alu_op,
  output logic             word_op,
  output logic             is_imm,
  output logic [11:0]      imm,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OP32  = 7'b0111011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  logic [6:0]  opcode;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic        accept;

  logic [3:0]  d_op;
  logic        d_word;
  logic        d_is_imm;
  logic        d_legal;
  logic [11:0] d_imm;
  logic [4:0]  d_rs2;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

`ifdef DECODER_IMM_EN
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_IMM32 = 7'b0011011;
  logic sh_lo;
  logic sh_hi;
  // RV64 shift immediates carry a 6-bit shamt, so only instr[31:26] is checked
  assign sh_lo = (XLEN == 64) ? (instr[31:26] == 6'b000000) : (f7 == F7_BASE);
  assign sh_hi = (XLEN == 64) ? (instr[31:26] == 6'b010000) : (f7 == F7_ALT);
`endif

  always_comb begin
    d_op     = ALU_ADD;
    d_word   = 1'b0;
    d_is_imm = 1'b0;
    d_legal  = 1'b0;
    d_imm    = 12'd0;
    d_rs2    = instr[24:20];
    case (opcode)
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          d_legal = 1'b1;
          case (f3)
            3'b000: d_op = ALU_ADD;
            3'b001: d_op = ALU_SLL;
            3'b010: d_op = ALU_SLT;
            3'b011: d_op = ALU_SLTU;
            3'b100: d_op = ALU_XOR;
            3'b101: d_op = ALU_SRL;
            3'b110: d_op = ALU_OR;
            3'b111: d_op = ALU_AND;
          endcase
        end else if (f7 == F7_ALT) begin
          if (f3 == 3'b000) begin
            d_legal = 1'b1;
            d_op    = ALU_SUB;
          end else if (f3 == 3'b101) begin
            d_legal = 1'b1;
            d_op    = ALU_SRA;
          end
        end
      end
      OPC_OP32: begin
        if (XLEN == 64) begin
          d_word = 1'b1;
          if (f7 == F7_BASE) begin
            if (f3 == 3'b000) begin d_legal = 1'b1; d_op = ALU_ADD; end
            if (f3 == 3'b001) begin d_legal = 1'b1; d_op = ALU_SLL; end
            if (f3 == 3'b101) begin d_legal = 1'b1; d_op = ALU_SRL; end
          end else if (f7 == F7_ALT) begin
            if (f3 == 3'b000) begin d_legal = 1'b1; d_op = ALU_SUB; end
            if (f3 == 3'b101) begin d_legal = 1'b1; d_op = ALU_SRA; end
          end
        end
      end
`ifdef DECODER_IMM_EN
      OPC_IMM: begin
        d_is_imm = 1'b1;
        d_rs2    = 5'd0;
        d_imm    = instr[31:20];
        case (f3)
          3'b000: begin d_legal = 1'b1; d_op = ALU_ADD; end
          3'b001: begin d_legal = sh_lo; d_op = ALU_SLL; end
          3'b010: begin d_legal = 1'b1; d_op = ALU_SLT; end
          3'b011: begin d_legal = 1'b1; d_op = ALU_SLTU; end
          3'b100: begin d_legal = 1'b1; d_op = ALU_XOR; end
          3'b101: begin d_legal = sh_lo || sh_hi; d_op = sh_hi ? ALU_SRA : ALU_SRL; end
          3'b110: begin d_legal = 1'b1; d_op = ALU_OR; end
          3'b111: begin d_legal = 1'b1; d_op = ALU_AND; end
        endcase
      end
      OPC_IMM32: begin
        if (XLEN == 64) begin
          d_is_imm = 1'b1;
          d_word   = 1'b1;
          d_rs2    = 5'd0;
          d_imm    = instr[31:20];
          // W shifts take a 5-bit shamt, so the full func7 field must match
          if (f3 == 3'b000) begin d_legal = 1'b1; d_op = ALU_ADD; end
          if (f3 == 3'b001 && f7 == F7_BASE) begin d_legal = 1'b1; d_op = ALU_SLL; end
          if (f3 == 3'b101 && f7 == F7_BASE) begin d_legal = 1'b1; d_op = ALU_SRL; end
          if (f3 == 3'b101 && f7 == F7_ALT) begin d_legal = 1'b1; d_op = ALU_SRA; end
        end
      end
`endif
      default: ;
    endcase
    if (!d_legal) begin
      d_op     = ALU_ADD;
      d_word   = 1'b0;
      d_is_imm = 1'b0;
      d_imm    = 12'd0;
      d_rs2    = instr[24:20];
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      rs1         <= 5'd0;
      rs2         <= 5'd0;
      rd          <= 5'd0;
      alu_op      <= 4'd0;
      word_op     <= 1'b0;
      is_imm      <= 1'b0;
      imm         <= 12'd0;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      rs1       <= instr[19:15];
      rs2       <= d_rs2;
      rd        <= instr[11:7];
      alu_op    <= d_op;
      word_op   <= d_word;
      is_imm    <= d_is_imm;
      imm       <= d_imm;
      illegal   <= !d_legal;
      if (!d_legal && illegal_cnt != {CNT_W{1'b1}})
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/rv_alu_decoder_pipe.md
Name: rv_alu_decoder_pipe

Overview:
- Parametrised, registered RISC-V integer ALU-instruction decoder with valid/ready handshake on input and output.
- Sits between fetch and the register-file/ALU stage.
- Decodes R-type OP, and when XLEN=64 also OP-32 (W forms), into register indices plus an encoded ALU operation.
- Flags illegal encodings and keeps a saturating count of them.

Parameters:
- XLEN, 32, datapath width; 32 or 64 only. 64 enables OP-32 (opcode 0111011) decode.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  instr is valid this cycle
- in_ready  output  1  decoder can accept instr
- instr  input  32  raw instruction word
- out_valid  output  1  decoded result held in output register
- out_ready  input  1  consumer accepts the result
- rs1  output  5  instr[19:15]
- rs2  output  5  instr[24:20]; 0 for I-type
- rd  output  5  instr[11:7]
- alu_op  output  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
- word_op  output  1  W-form (32-bit result, sign-extended)
- is_imm  output  1  I-type ALU op (optional feature only)
- imm  output  12  instr[31:20] for I-type, else 0
- illegal  output  1  encoding not supported
- illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset (async, rst=1): out_valid=0, rs1=rs2=rd=0, alu_op=0, word_op=0, is_imm=0, imm=0, illegal=0, illegal_cnt=0. An in-flight result is discarded; no partial state survives.
- in_ready = !out_valid || out_ready (combinational). Accept happens on in_valid && in_ready.
- Latency is 1 cycle. A word accepted at edge N is presented from edge N+1 and held stable while out_valid && !out_ready.
- Full throughput: back-to-back accepts with out_ready=1 give one result per cycle.
- Output register update: on accept, load all decoded fields and set out_valid=1.
- Output register drain: if there is no accept and out_ready=1, clear out_valid. Data fields may hold their last value.
- OP (0110011), func7=0000000, func3 000..111: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
- OP (0110011), func7=0100000: func3 000 gives SUB, func3 101 gives SRA; any other func3 is illegal.
- OP-32 (0111011), XLEN=64 only, word_op=1:
  - func7=0000000: func3 000 gives ADD, 001 gives SLL, 101 gives SRL.
  - func7=0100000: func3 000 gives SUB, 101 gives SRA.
  - All other combinations are illegal.
- With XLEN=32, opcode 0111011 is illegal.
- Any other opcode or func7 (including M-extension 0000001) is illegal.
- Illegal result: illegal=1, alu_op=0, word_op=0, is_imm=0. Register fields still pass through unchanged.
- illegal_cnt increments by 1 on each accepted illegal instruction and saturates at all-ones. It is never cleared except by rst.
- Simultaneous accept and drain: the new result replaces the old with out_valid kept at 1 (no bubble).
- in_valid deasserted while stalled: no effect on held output.

Optional Feature:
- Macro DECODER_IMM_EN.
- Defined: OP-IMM (0010011) decodes ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI with is_imm=1, rs2=0, imm=instr[31:20].
  - Shift-immediate checks, XLEN=32: instr[31:25] must be 0000000 (SLLI/SRLI) or 0100000 (SRAI).
  - Shift-immediate checks, XLEN=64: instr[31:26] must be 000000 or 010000.
  - With XLEN=64, OP-IMM-32 (0011011) also decodes ADDIW, SLLIW, SRLIW, SRAIW with word_op=1.
  - Failing checks are illegal.
- Undefined: is_imm and imm are tied to 0, and these opcodes are illegal.

Test Plan:
- Reset, then instr=0x002081B3 (add x3,x1,x2), out_ready=1 → next cycle out_valid=1, rs1=1, rs2=2, rd=3, alu_op=0, illegal=0.
- instr=0x407302B3 (sub x5,x6,x7) with out_ready=0 for 3 cycles → out_valid stays 1, fields stable, in_ready=0; release gives single drain.
- XLEN=64: instr=0x003100BB (addw x1,x2,x3) → alu_op=0, word_op=1. XLEN=32: same word → illegal=1, illegal_cnt=1.
- instr=0x02208133 (mul) → illegal=1, rd=2. With CNT_W=2, 5 illegal accepts → illegal_cnt=3.
- DECODER_IMM_EN defined: instr=0xFFF00093 (addi x1,x0,-1) → is_imm=1, imm=0xFFF, rs2=0, alu_op=0. Undefined: same word → illegal=1.
- rst asserted mid-stall with out_valid=1 → out_valid=0 and illegal_cnt=0 immediately (asynchronous); first result appears one cycle after the next accept.
